// File: rtl/mem_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by the requester and memory sides of mem_rd_arbiter.
interface mem_rd_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 1
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-source AXI4 read arbiter (core=0, DMA=1): round-robin AR grant, ID-MSB source tagging, per-source burst cap.
// Optional performance counters enabled by defining MEM_RD_ARB_PERF_EN.
module mem_rd_arbiter #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ID_W      = 1,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                coreclk,
    input  logic                corersts,
    mem_rd_arbiter_if.slave     s0,
    mem_rd_arbiter_if.slave     s1,
    mem_rd_arbiter_if.master    m,
    output logic                prot_err
`ifdef MEM_RD_ARB_PERF_EN
    ,
    output logic [31:0]         perf_grant0,
    output logic [31:0]         perf_grant1,
    output logic [31:0]         perf_stall
`endif
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t           state, state_nxt;
    logic             rr_last, rr_last_nxt;
    logic [CNT_W-1:0] cnt0, cnt1, cnt0_nxt, cnt1_nxt;
    logic             elig0, elig1;
    logic             ar_hs0, ar_hs1;
    logic             rsrc, rl_hs0, rl_hs1, err_set;

    assign elig0 = s0.arvalid & (cnt0 != CNT_MAX);
    assign elig1 = s1.arvalid & (cnt1 != CNT_MAX);

    // Grant FSM: arbitration decided in IDLE, grant held until the AR handshake.
    always_comb begin
        state_nxt   = state;
        rr_last_nxt = rr_last;
        ar_hs0      = 1'b0;
        ar_hs1      = 1'b0;
        m.arvalid   = 1'b0;
        m.arid      = '0;
        m.araddr    = '0;
        m.arlen     = '0;
        m.arsize    = '0;
        m.arburst   = '0;
        s0.arready  = 1'b0;
        s1.arready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (elig0 && elig1)  state_nxt = rr_last ? GRANT0 : GRANT1;
                else if (elig0)      state_nxt = GRANT0;
                else if (elig1)      state_nxt = GRANT1;
            end
            GRANT0: begin
                m.arvalid  = s0.arvalid & ~corersts;
                m.arid     = {1'b0, s0.arid[ID_W-1:0]};
                m.araddr   = s0.araddr[ADDR_W-1:0];
                m.arlen    = s0.arlen;
                m.arsize   = s0.arsize;
                m.arburst  = s0.arburst;
                s0.arready = m.arready & ~corersts;
                ar_hs0     = s0.arvalid & m.arready & ~corersts;
                if (ar_hs0) begin
                    state_nxt   = IDLE;
                    rr_last_nxt = 1'b0;
                end
            end
            GRANT1: begin
                m.arvalid  = s1.arvalid & ~corersts;
                m.arid     = {1'b1, s1.arid[ID_W-1:0]};
                m.araddr   = s1.araddr[ADDR_W-1:0];
                m.arlen    = s1.arlen;
                m.arsize   = s1.arsize;
                m.arburst  = s1.arburst;
                s1.arready = m.arready & ~corersts;
                ar_hs1     = s1.arvalid & m.arready & ~corersts;
                if (ar_hs1) begin
                    state_nxt   = IDLE;
                    rr_last_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Zero-latency R routing keyed on the source bit of the returned ID.
    always_comb begin
        rsrc      = m.rid[ID_W];
        s0.rvalid = m.rvalid & ~rsrc & ~corersts;
        s1.rvalid = m.rvalid &  rsrc & ~corersts;
        s0.rid    = m.rid[ID_W-1:0];
        s1.rid    = m.rid[ID_W-1:0];
        s0.rdata  = m.rdata[DATA_W-1:0];
        s1.rdata  = m.rdata[DATA_W-1:0];
        s0.rresp  = m.rresp;
        s1.rresp  = m.rresp;
        s0.rlast  = m.rlast;
        s1.rlast  = m.rlast;
        m.rready  = (rsrc ? s1.rready : s0.rready) & ~corersts;
        rl_hs0    = m.rvalid & m.rready & m.rlast & ~rsrc;
        rl_hs1    = m.rvalid & m.rready & m.rlast &  rsrc;
    end

    // Outstanding-burst counters; an underflowing rlast is flagged, not counted.
    always_comb begin
        cnt0_nxt = cnt0;
        cnt1_nxt = cnt1;
        if (ar_hs0 && !rl_hs0)                         cnt0_nxt = cnt0 + CNT_W'(1);
        else if (!ar_hs0 && rl_hs0 && cnt0 != '0)      cnt0_nxt = cnt0 - CNT_W'(1);
        if (ar_hs1 && !rl_hs1)                         cnt1_nxt = cnt1 + CNT_W'(1);
        else if (!ar_hs1 && rl_hs1 && cnt1 != '0)      cnt1_nxt = cnt1 - CNT_W'(1);
        err_set = (rl_hs0 && cnt0 == '0) || (rl_hs1 && cnt1 == '0);
    end

    always_ff @(posedge coreclk) begin
        if (corersts) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            cnt0     <= '0;
            cnt1     <= '0;
            prot_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_last  <= rr_last_nxt;
            cnt0     <= cnt0_nxt;
            cnt1     <= cnt1_nxt;
            prot_err <= prot_err | err_set;
        end
    end

`ifdef MEM_RD_ARB_PERF_EN
    logic stall;
    assign stall = (s0.arvalid && cnt0 == CNT_MAX) || (s1.arvalid && cnt1 == CNT_MAX);

    always_ff @(posedge coreclk) begin
        if (corersts) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            perf_grant0 <= perf_grant0 + 32'(ar_hs0);
            perf_grant1 <= perf_grant1 + 32'(ar_hs1);
            perf_stall  <= perf_stall + 32'(stall);
        end
    end
`endif
endmodule
